// File: rtl/axi4lite_pkg.sv
// Shared types, constants and the address decoder for the AXI4-Lite register slave.
// Contents:
//   resp_t        AXI response codes (OKAY / SLVERR)
//   REGn_OFS      byte offsets of the implemented registers
//   addr_dec_t    decoder result (hit flag + register index)
//   wr_req_t      committed write payload handed from the write controller to the register array
//   addr_decode() maps a byte address onto a register index and range check
package axi4lite_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STRB_W     = DATA_W / 8;
  localparam int unsigned IDX_W      = 8;
  localparam int unsigned DEC_ADDR_W = 32;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  localparam logic [7:0] REG0_OFS = 8'h00;
  localparam logic [7:0] REG1_OFS = 8'h04;
  localparam logic [7:0] REG2_OFS = 8'h08;
  localparam logic [7:0] REG3_OFS = 8'h0C;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } addr_dec_t;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wr_req_t;

  // Word index is the byte address with the two byte-lane bits dropped.
  function automatic addr_dec_t addr_decode(input logic [DEC_ADDR_W-1:0] addr,
                                            input int unsigned           num_regs);
    logic [DEC_ADDR_W-1:0] word;
    addr_dec_t             dec;
    word     = addr >> 2;
    dec.hit  = (word < num_regs);
    dec.idx  = IDX_W'(word);
    return dec;
  endfunction

endpackage

// File: rtl/axi4lite_wr_ctrl.sv
// Write-side controller: holds AW and W independently, commits when both are present,
// and answers on the B channel. Only one write is outstanding at a time.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   awaddr_i/awvalid_i/awready_o  write address channel
//   wdata_i/wstrb_i/wvalid_i/wready_o  write data channel
//   bresp_o/bvalid_o/bready_i     write response channel
//   commit_en_c                   combinational: an in-range write commits at this edge
//   commit_req_c                  combinational: register index, data and strobes of that write
module axi4lite_wr_ctrl
  import axi4lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [STRB_W-1:0]     wstrb_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [1:0]            bresp_o,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  output logic                  commit_en_c,
  output wr_req_t               commit_req_c
);

  logic                  aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_W-1:0]     w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  resp_t                 bresp_q, bresp_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;

  logic                  aw_hs, w_hs, b_hs, commit;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_W-1:0]     cur_data;
  logic [STRB_W-1:0]     cur_strb;
  addr_dec_t             dec;

  assign aw_hs = awvalid_i & awready_q;
  assign w_hs  = wvalid_i & wready_q;
  assign b_hs  = bvalid_q & bready_i;

  // A channel handshaking this cycle counts as present even though its hold is still empty.
  assign commit   = (aw_full_q | aw_hs) & (w_full_q | w_hs);
  assign cur_addr = aw_full_q ? aw_addr_q : awaddr_i;
  assign cur_data = w_full_q  ? w_data_q  : wdata_i;
  assign cur_strb = w_full_q  ? w_strb_q  : wstrb_i;
  assign dec      = addr_decode(DEC_ADDR_W'(cur_addr), NUM_REGS);

  assign commit_en_c  = commit & dec.hit;
  assign commit_req_c = '{idx: dec.idx, data: cur_data, strb: cur_strb};

  // Next-state for holds, response and the registered readys.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = awaddr_i;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = wdata_i;
      w_strb_d = wstrb_i;
    end

    // Readys are low while BVALID is up, so commit and B handshake never coincide.
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = dec.hit ? RESP_OKAY : RESP_SLVERR;
    end else if (b_hs) begin
      bvalid_d = 1'b0;
    end

    awready_d = ~aw_full_d & ~bvalid_d;
    wready_d  = ~w_full_d & ~bvalid_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
    end
  end

  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;

endmodule

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers at offsets 4*k.
// Write and read channels are independent; byte strobes are honoured; accesses outside
// the implemented range answer SLVERR. Register contents are also driven on REG_OUT.
// Ports:
//   ACLK, ARESETN                 clock, asynchronous active-low reset
//   AW*/W*/B*                     AXI4-Lite write channels (AWPROT ignored)
//   AR*/R*                        AXI4-Lite read channels (ARPROT ignored)
//   REG_OUT                       register k on bits [32k+31:32k]
module axi4lite_reg_slave
  import axi4lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [DATA_WIDTH*NUM_REGS-1:0] REG_OUT
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  commit_en;
  wr_req_t               commit_req;

  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_t                 rresp_q, rresp_d;

  logic                  ar_hs, r_hs;
  addr_dec_t             rd_dec;
  logic [DATA_WIDTH-1:0] rd_word;

  // Protection attributes carry no meaning for this block.
  logic unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT};

  axi4lite_wr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_wr_ctrl (
    .clk_i        (ACLK),
    .rst_ni       (ARESETN),
    .awaddr_i     (AWADDR),
    .awvalid_i    (AWVALID),
    .awready_o    (AWREADY),
    .wdata_i      (WDATA),
    .wstrb_i      (WSTRB),
    .wvalid_i     (WVALID),
    .wready_o     (WREADY),
    .bresp_o      (BRESP),
    .bvalid_o     (BVALID),
    .bready_i     (BREADY),
    .commit_en_c  (commit_en),
    .commit_req_c (commit_req)
  );

  // Byte-masked register update on a committed in-range write.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (commit_en && (commit_req.idx == IDX_W'(k))) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (commit_req.strb[b]) begin
            regs_d[k][8*b +: 8] = commit_req.data[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  assign ar_hs  = ARVALID & arready_q;
  assign r_hs   = rvalid_q & RREADY;
  assign rd_dec = addr_decode(DEC_ADDR_W'(ARADDR), NUM_REGS);

  // Read mux uses the pre-edge register values, so a same-edge write is not visible.
  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (rd_dec.idx == IDX_W'(k)) begin
        rd_word = regs_q[k];
      end
    end
  end

  // Read channel next-state; ARREADY is low whenever RVALID is up.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (rd_dec.hit) begin
        rdata_d = rd_word;
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
    arready_d = ~rvalid_d;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
    assign REG_OUT[DATA_WIDTH*k +: DATA_WIDTH] = regs_q[k];
  end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Self-checking bench for axi4lite_reg_slave: a reference register model feeds
// expected B and R responses into queues that are popped as the DUT answers.
module tb_axi4lite_reg_slave;
  import axi4lite_pkg::*;

  localparam int unsigned AW  = 6;
  localparam int unsigned NR  = 4;
  localparam int unsigned TMO = 50;

  logic           ACLK = 1'b0;
  logic           ARESETN = 1'b0;
  logic [AW-1:0]  AWADDR = '0;
  logic [2:0]     AWPROT = '0;
  logic           AWVALID = 1'b0;
  logic           AWREADY;
  logic [31:0]    WDATA = '0;
  logic [3:0]     WSTRB = '0;
  logic           WVALID = 1'b0;
  logic           WREADY;
  logic [1:0]     BRESP;
  logic           BVALID;
  logic           BREADY = 1'b0;
  logic [AW-1:0]  ARADDR = '0;
  logic [2:0]     ARPROT = '0;
  logic           ARVALID = 1'b0;
  logic           ARREADY;
  logic [31:0]    RDATA;
  logic [1:0]     RRESP;
  logic           RVALID;
  logic           RREADY = 1'b0;
  logic [32*NR-1:0] REG_OUT;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model [NR];
  logic [1:0]  exp_b_q [$];
  logic [33:0] exp_r_q [$];

  axi4lite_reg_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (AW),
    .NUM_REGS   (NR)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .AWADDR  (AWADDR),
    .AWPROT  (AWPROT),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARPROT  (ARPROT),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .REG_OUT (REG_OUT)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [32*NR-1:0] model_flat();
    logic [32*NR-1:0] v;
    for (int k = 0; k < NR; k++) v[32*k +: 32] = model[k];
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NR; k++) model[k] = '0;
  endtask

  // Scoreboard pushes: expected response computed from the model at stimulus time.
  task automatic push_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int unsigned w;
    w = 32'(addr) >> 2;
    if (w < NR) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[w][8*b +: 8] = data[8*b +: 8];
      exp_b_q.push_back(2'b00);
    end else begin
      exp_b_q.push_back(2'b10);
    end
  endtask

  task automatic push_read(input logic [AW-1:0] addr);
    int unsigned w;
    w = 32'(addr) >> 2;
    if (w < NR) exp_r_q.push_back({model[w], 2'b00});
    else        exp_r_q.push_back({32'h0, 2'b10});
  endtask

  // Holds each asserted VALID until its READY was seen high; entered and left at a negedge.
  task automatic run_handshakes(input string name);
    int  n;
    logic aw_go, w_go, ar_go;
    n = 0;
    while ((AWVALID || WVALID || ARVALID) && n < TMO) begin
      aw_go = AWVALID && (AWREADY === 1'b1);
      w_go  = WVALID && (WREADY === 1'b1);
      ar_go = ARVALID && (ARREADY === 1'b1);
      @(negedge ACLK);
      n++;
      if (aw_go) AWVALID = 1'b0;
      if (w_go)  WVALID  = 1'b0;
      if (ar_go) ARVALID = 1'b0;
    end
    n_cmp++;
    if (AWVALID || WVALID || ARVALID) begin
      n_err++;
      $display("FAIL %s_handshake: pending aw/w/ar=%b%b%b after %0d cycles, required all accepted",
               name, AWVALID, WVALID, ARVALID, n);
      AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    end
  endtask

  task automatic collect_b(input string name);
    int n;
    logic [1:0] exp;
    n = 0;
    BREADY = 1'b1;
    while (BVALID !== 1'b1 && n < TMO) begin @(negedge ACLK); n++; end
    n_cmp++;
    if (BVALID !== 1'b1) begin
      n_err++;
      $display("FAIL %s_bvalid: BVALID=%b after %0d cycles, required 1", name, BVALID, n);
    end else if (exp_b_q.size() == 0) begin
      n_err++;
      $display("FAIL %s_bresp: unexpected response BRESP=%b, required none", name, BRESP);
    end else begin
      exp = exp_b_q.pop_front();
      if (BRESP !== exp) begin
        n_err++;
        $display("FAIL %s_bresp: got %b, required %b", name, BRESP, exp);
      end
    end
    @(negedge ACLK);
    BREADY = 1'b0;
    n_cmp++;
    if (BVALID !== 1'b0) begin
      n_err++;
      $display("FAIL %s_bvalid_drop: BVALID=%b after handshake, required 0", name, BVALID);
    end
  endtask

  task automatic collect_r(input string name);
    int n;
    logic [33:0] exp;
    n = 0;
    RREADY = 1'b1;
    while (RVALID !== 1'b1 && n < TMO) begin @(negedge ACLK); n++; end
    n_cmp++;
    if (RVALID !== 1'b1) begin
      n_err++;
      $display("FAIL %s_rvalid: RVALID=%b after %0d cycles, required 1", name, RVALID, n);
    end else if (exp_r_q.size() == 0) begin
      n_err++;
      $display("FAIL %s_rdata: unexpected read data %h, required none", name, RDATA);
    end else begin
      exp = exp_r_q.pop_front();
      if ({RDATA, RRESP} !== exp) begin
        n_err++;
        $display("FAIL %s_rdata: got data %h resp %b, required data %h resp %b",
                 name, RDATA, RRESP, exp[33:2], exp[1:0]);
      end
    end
    @(negedge ACLK);
    RREADY = 1'b0;
    n_cmp++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      n_err++;
      $display("FAIL %s_rvalid_drop: RVALID=%b ARREADY=%b after handshake, required 0/1",
               name, RVALID, ARREADY);
    end
  endtask

  // order: 0 = AW and W together, 1 = AW then W, 2 = W then AW three cycles later.
  task automatic do_write(input string name, input logic [AW-1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int order);
    push_write(addr, data, strb);
    AWADDR = addr; WDATA = data; WSTRB = strb;
    if (order == 0) begin
      AWVALID = 1'b1; WVALID = 1'b1;
      run_handshakes(name);
    end else if (order == 1) begin
      AWVALID = 1'b1;
      run_handshakes(name);
      repeat (2) @(negedge ACLK);
      WVALID = 1'b1;
      run_handshakes(name);
    end else begin
      WVALID = 1'b1;
      run_handshakes(name);
      repeat (3) @(negedge ACLK);
      AWVALID = 1'b1;
      run_handshakes(name);
    end
    collect_b(name);
  endtask

  task automatic do_read(input string name, input logic [AW-1:0] addr);
    push_read(addr);
    ARADDR = addr; ARVALID = 1'b1;
    run_handshakes(name);
    collect_r(name);
  endtask

  task automatic check_regout(input string name);
    n_cmp++;
    if (REG_OUT !== model_flat()) begin
      n_err++;
      $display("FAIL %s_reg_out: got %h, required %h", name, REG_OUT, model_flat());
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    model_clear();
    repeat (2) @(negedge ACLK);
    n_cmp++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: aw/w/ar ready, bvalid, rvalid, bresp, rresp = %b%b%b %b %b %b %b, required all 0",
               AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP);
    end
    n_cmp++;
    if (RDATA !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h, required 0", RDATA);
    end
    check_regout("reset");
    ARESETN = 1'b1;
    @(negedge ACLK);
    n_cmp++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      n_err++;
      $display("FAIL reset_release_ready: aw/w/ar ready = %b%b%b, required 111", AWREADY, WREADY, ARREADY);
    end
  endtask

  task automatic test_seq_write_read();
    do_write("seq_w0", AW'(REG0_OFS), 32'h1, 4'hF, 0);
    do_write("seq_w1", AW'(REG1_OFS), 32'h2, 4'hF, 0);
    do_write("seq_w2", AW'(REG2_OFS), 32'h3, 4'hF, 0);
    do_write("seq_w3", AW'(REG3_OFS), 32'h4, 4'hF, 0);
    do_read("seq_r0", AW'(REG0_OFS));
    do_read("seq_r1", AW'(REG1_OFS));
    do_read("seq_r2", AW'(REG2_OFS));
    do_read("seq_r3", AW'(REG3_OFS));
    n_cmp++;
    if (REG_OUT !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
      n_err++;
      $display("FAIL seq_reg_out: got %h, required 4/3/2/1", REG_OUT);
    end
  endtask

  task automatic test_channel_order();
    do_write("ord_w_first", AW'(REG1_OFS), 32'hAAAA5555, 4'hF, 2);
    check_regout("ord_w_first");
    do_write("ord_aw_first", AW'(REG1_OFS), 32'h12345678, 4'hF, 1);
    check_regout("ord_aw_first");
    do_write("ord_same", AW'(REG1_OFS), 32'h0BADCAFE, 4'hF, 0);
    do_read("ord_readback", AW'(REG1_OFS));
  endtask

  // AR and a write commit to the same register on one edge: read sees the old value.
  task automatic test_same_edge();
    push_read(AW'(REG1_OFS));
    push_write(AW'(REG1_OFS), 32'h5A5A0001, 4'hF);
    AWADDR = AW'(REG1_OFS); WDATA = 32'h5A5A0001; WSTRB = 4'hF;
    ARADDR = AW'(REG1_OFS);
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    run_handshakes("same_edge");
    collect_b("same_edge");
    collect_r("same_edge_old");
    do_read("same_edge_new", AW'(REG1_OFS));
  endtask

  task automatic test_strobes();
    do_write("strb_fill", AW'(REG0_OFS), 32'hFFFFFFFF, 4'hF, 0);
    do_write("strb_mask", AW'(REG0_OFS), 32'h00000000, 4'h5, 0);
    do_read("strb_read", AW'(REG0_OFS));
    n_cmp++;
    if (REG_OUT[31:0] !== 32'hFF00FF00) begin
      n_err++;
      $display("FAIL strb_reg0: got %h, required ff00ff00", REG_OUT[31:0]);
    end
  endtask

  task automatic test_out_of_range();
    do_write("oor_write", 6'h10, 32'h0000DEAD, 4'hF, 0);
    check_regout("oor_write");
    do_read("oor_read", 6'h3C);
  endtask

  task automatic test_backpressure();
    push_write(AW'(REG3_OFS), 32'hCAFEF00D, 4'hF);
    AWADDR = AW'(REG3_OFS); WDATA = 32'hCAFEF00D; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    run_handshakes("bp_write");
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({BVALID, BRESP, AWREADY, WREADY} !== {1'b1, exp_b_q[0], 2'b00}) begin
        n_err++;
        $display("FAIL bp_write_hold: cycle %0d bvalid/bresp/awready/wready=%b/%b/%b/%b, required 1/%b/0/0",
                 i, BVALID, BRESP, AWREADY, WREADY, exp_b_q[0]);
      end
      @(negedge ACLK);
    end
    check_regout("bp_write");
    collect_b("bp_write");

    push_read(AW'(REG1_OFS));
    ARADDR = AW'(REG1_OFS); ARVALID = 1'b1;
    run_handshakes("bp_read");
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({RVALID, RDATA, RRESP, ARREADY} !== {1'b1, exp_r_q[0], 1'b0}) begin
        n_err++;
        $display("FAIL bp_read_hold: cycle %0d rvalid/rdata/rresp/arready=%b/%h/%b/%b, required 1/%h/%b/0",
                 i, RVALID, RDATA, RRESP, ARREADY, exp_r_q[0][33:2], exp_r_q[0][1:0]);
      end
      @(negedge ACLK);
    end
    collect_r("bp_read");
  endtask

  task automatic test_async_reset();
    push_write(AW'(REG2_OFS), 32'h77, 4'hF);
    AWADDR = AW'(REG2_OFS); WDATA = 32'h77; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    run_handshakes("arst_write");
    n_cmp++;
    if (BVALID !== 1'b1 || REG_OUT[95:64] !== 32'h77) begin
      n_err++;
      $display("FAIL arst_pre: BVALID=%b reg2=%h, required 1 / 00000077", BVALID, REG_OUT[95:64]);
    end
    @(posedge ACLK);
    #2;
    ARESETN = 1'b0;
    #1;
    n_cmp++;
    if (BVALID !== 1'b0 || REG_OUT !== '0) begin
      n_err++;
      $display("FAIL arst_immediate: BVALID=%b REG_OUT=%h, required 0 / 0", BVALID, REG_OUT);
    end
    model_clear();
    exp_b_q.delete();
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    do_read("arst_read", AW'(REG2_OFS));
    check_regout("arst_final");
  endtask

  initial begin
    test_reset();
    test_seq_write_read();
    test_channel_order();
    test_same_edge();
    test_strobes();
    test_out_of_range();
    test_backpressure();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi4lite_reg_slave.md
Name: axi4lite_reg_slave

Overview:
AXI4-Lite slave register block that sits directly downstream of the AXI master (the VIP master in simulation, the PS or interconnect in hardware). It exposes NUM_REGS 32-bit read/write registers at word-aligned offsets from 0x00. Write and read channels run independently, byte strobes are honoured, and out-of-range accesses are answered with SLVERR. The register contents are also driven out in parallel to the user logic.

Parameters:
DATA_WIDTH, 32, AXI data width; only 32 is supported.
ADDR_WIDTH, 6, AXI address width in bits; byte address space is 2^ADDR_WIDTH.
NUM_REGS, 4, number of implemented registers, at offsets 4*k for k = 0 .. NUM_REGS-1; must be at most 2^(ADDR_WIDTH-2).

Ports:
ACLK  in  1  clock; all logic is rising-edge.
ARESETN  in  1  asynchronous, active-low reset.
AWADDR  in  ADDR_WIDTH  write address.
AWPROT  in  3  ignored.
AWVALID  in  1  write address valid.
AWREADY  out  1  write address ready.
WDATA  in  32  write data.
WSTRB  in  4  byte strobes.
WVALID  in  1  write data valid.
WREADY  out  1  write data ready.
BRESP  out  2  write response.
BVALID  out  1  write response valid.
BREADY  in  1  write response ready.
ARADDR  in  ADDR_WIDTH  read address.
ARPROT  in  3  ignored.
ARVALID  in  1  read address valid.
ARREADY  out  1  read address ready.
RDATA  out  32  read data.
RRESP  out  2  read response.
RVALID  out  1  read valid.
RREADY  in  1  read ready.
REG_OUT  out  32*NUM_REGS  register k is on bits [32k+31:32k].

Behaviour:
- Clock and reset: one clock, ACLK. ARESETN is asynchronous and active-low. Assertion takes effect immediately, regardless of clock. Deassertion is sampled on ACLK.
- Reset values: all registers 0; AWREADY, WREADY, ARREADY, BVALID and RVALID 0; BRESP, RRESP and RDATA 0. The internal AW and W hold flags are cleared.
- First cycle after reset release: AWREADY, WREADY and ARREADY go to 1 (all readys are registered).
- Write address capture: AWREADY=1 while the AW hold is empty and BVALID=0. An AW handshake latches AWADDR into the hold and drops AWREADY at the next edge.
- Write data capture: WREADY=1 while the W hold is empty and BVALID=0. A W handshake latches WDATA and WSTRB into the hold and drops WREADY at the next edge.
- AW and W arrival order: either channel may arrive first or both in the same cycle.
- Write commit: occurs at the edge where both holds become full (or where one is already full and the other handshakes).
  - In range (addr[ADDR_WIDTH-1:2] < NUM_REGS): byte i of the register is updated iff WSTRB[i]=1, and BRESP=OKAY (2'b00).
  - Out of range: no register changes, and BRESP=SLVERR (2'b10).
  - addr[1:0] is ignored.
- Write response: BVALID goes to 1 after the commit edge and the holds clear. BVALID holds, with BRESP stable, until a BREADY handshake. AWREADY and WREADY return to 1 on the edge after that handshake. Only one write is outstanding at a time.
- Read: ARREADY=1 while RVALID=0. An AR handshake at edge N:
  - RDATA is loaded from the register contents as they stood before edge N.
  - RRESP=OKAY for an in-range address. Out of range gives RDATA=0 and RRESP=SLVERR.
  - RVALID=1 and ARREADY=0 after edge N.
  - RVALID, RDATA and RRESP hold until an RREADY handshake; ARREADY=1 on the following cycle.
- Read/write same edge: a read whose AR handshake coincides with a write commit to the same register returns the old value. Any read whose AR handshake is at a later edge returns the new value.
- Latency: AW+W in the same cycle gives BVALID one cycle later. AR gives RVALID one cycle later.
- REG_OUT reflects the registers combinationally from the flops, so it updates after the commit edge.
- Reset mid-transaction: the pending hold, BVALID and RVALID are dropped immediately. There is no partial register update.

Decomposition:
- Shared package axi4lite_pkg:
  - resp_t with RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Register offset constants REG0_OFS through REG3_OFS.
  - A function that returns in-range / index for a given address.
- Natural sub-module: axi4lite_wr_ctrl, covering the AW/W hold, commit and B channel. The read path and register array stay in the top.

Test Plan:
- Sequential write then read: write 0x1, 0x2, 0x3, 0x4 to offsets 0x0, 0x4, 0x8, 0xC with WSTRB=0xF, then read them back. All return the written data with RRESP=OKAY and BRESP=OKAY, and REG_OUT={4,3,2,1}.
- Channel ordering: write to 0x4 three ways:
  - W then AW three cycles later, data 0xAAAA5555.
  - AW then W, data 0x12345678.
  - Both in the same cycle.
  - Each gives exactly one BVALID, and the register holds the latest data.
- Byte strobes: reg0=0xFFFFFFFF, then write 0x00000000 with WSTRB=0x5. A read of 0x0 returns 0xFF00FF00.
- Out of range: a write to 0x10 with data 0xDEAD gives BRESP=SLVERR and all registers unchanged. A read of 0x3C gives RDATA=0 and RRESP=SLVERR.
- Backpressure: BREADY and RREADY held low for 10 cycles. BVALID, RVALID and data stay stable, and AWREADY, WREADY and ARREADY stay 0 until the respective handshake.
- Async reset: ARESETN pulled low mid-cycle while BVALID=1 after writing 0x77 to 0x8. BVALID and REG_OUT clear immediately without a clock edge, and a subsequent read of 0x8 returns 0.
